// File: rtl/mc_pkg.sv
// mc_pkg: shared types and default constants for the Monte-Carlo run controller.
//   mc_state_e       - run-sequencer FSM state encoding
//   MC_LANES         - default number of generator/accumulator lanes
//   MC_CLEAR_CYCLES  - default cycles the engine is held in clear
//   MC_FLUSH_CYCLES  - default pipeline warm-up cycles
//   MC_DRAIN_CYCLES  - default accumulator settle cycles
package mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FLUSH = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } mc_state_e;

    localparam int MC_LANES        = 5;
    localparam int MC_CLEAR_CYCLES = 2;
    localparam int MC_FLUSH_CYCLES = 8;
    localparam int MC_DRAIN_CYCLES = 4;

endpackage

// File: rtl/mc_phase_counter.sv
// mc_phase_counter: loadable 32-bit down-counter shared by all timed phases.
//   clk, reset  - clock, synchronous active-high reset
//   load        - load load_value (takes priority over counting)
//   load_value  - cycles remaining minus one for the phase being entered
//   zero        - high while the count is 0, i.e. on the last cycle of a phase
// The counter stops at zero; the owner reloads it on every phase entry.
module mc_phase_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic        zero
);

    logic [31:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != 32'd0) begin
            count <= count - 32'd1;
        end
    end

    assign zero = (count == 32'd0);

endmodule

// File: rtl/mc_run_controller.sv
// mc_run_controller: sequences one Monte-Carlo pricing run on the engine.
//   Inputs : clk, reset (sync, active-high), start, abort, result_ack,
//            n_samples (RUN cycles per lane), KerT_in/Se05sigmaT_in/sigmaSqrtT_in
//            (signed pricing parameters), mode_in, sum_in, sum_square_in
//            (merged engine accumulators).
//   Outputs: KerT/Se05sigmaT/sigmaSqrtT/Mode (parameters latched at start),
//            Status (accumulate enable), engine_nreset (engine clear, active
//            low), busy, done, sum_result/sum_square_result (captured sums),
//            sample_total (n_samples x LANES), progress (RUN cycles done),
//            state (FSM state for observation).
// Sequence: IDLE -> CLEAR -> FLUSH -> RUN -> DRAIN -> DONE -> IDLE.
// Handshake: start is honoured only in IDLE; done stays high in DONE until
// result_ack is sampled high; abort in any non-IDLE state wins over both.
module mc_run_controller
    import mc_pkg::*;
#(
    parameter int LANES        = MC_LANES,
    parameter int CLEAR_CYCLES = MC_CLEAR_CYCLES,
    parameter int FLUSH_CYCLES = MC_FLUSH_CYCLES,
    parameter int DRAIN_CYCLES = MC_DRAIN_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               result_ack,
    input  logic [31:0]        n_samples,
    input  logic signed [15:0] KerT_in,
    input  logic signed [15:0] Se05sigmaT_in,
    input  logic signed [15:0] sigmaSqrtT_in,
    input  logic               mode_in,
    input  logic [63:0]        sum_in,
    input  logic [63:0]        sum_square_in,
    output logic signed [15:0] KerT,
    output logic signed [15:0] Se05sigmaT,
    output logic signed [15:0] sigmaSqrtT,
    output logic               Mode,
    output logic               Status,
    output logic               engine_nreset,
    output logic               busy,
    output logic               done,
    output logic [63:0]        sum_result,
    output logic [63:0]        sum_square_result,
    output logic [34:0]        sample_total,
    output logic [31:0]        progress,
    output mc_state_e          state
);

    mc_state_e   state_next;
    logic        accept;
    logic        cnt_load;
    logic [31:0] cnt_value;
    logic        cnt_zero;
    logic [31:0] n_q;

    mc_phase_counter u_phase_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .zero       (cnt_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; also loads the phase counter with (length - 1) on
    // every phase entry so cnt_zero marks the final cycle of that phase.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cnt_load   = 1'b0;
        cnt_value  = '0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    accept     = 1'b1;
                    state_next = ST_CLEAR;
                    cnt_load   = 1'b1;
                    cnt_value  = 32'(CLEAR_CYCLES - 1);
                end
            end
            ST_CLEAR: begin
                if (cnt_zero) begin
                    state_next = ST_FLUSH;
                    cnt_load   = 1'b1;
                    cnt_value  = 32'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    if (n_q == 32'd0) begin
                        state_next = ST_DRAIN;
                        cnt_value  = 32'(DRAIN_CYCLES - 1);
                    end else begin
                        state_next = ST_RUN;
                        cnt_value  = n_q - 32'd1;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_zero) begin
                    state_next = ST_DRAIN;
                    cnt_load   = 1'b1;
                    cnt_value  = 32'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if (cnt_zero) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (result_ack) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort && state != ST_IDLE) begin
            state_next = ST_IDLE;
            cnt_load   = 1'b0;
        end
    end

    // Output logic decoded from the current state
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // Registered outputs and shadow datapath. Status and engine_nreset are
    // derived from the next state so they line up with the state register
    // while staying flop outputs; they can never both be active.
    always_ff @(posedge clk) begin
        if (reset) begin
            Status            <= 1'b0;
            engine_nreset     <= 1'b0;
            KerT              <= '0;
            Se05sigmaT        <= '0;
            sigmaSqrtT        <= '0;
            Mode              <= 1'b0;
            n_q               <= '0;
            sample_total      <= '0;
            progress          <= '0;
            sum_result        <= '0;
            sum_square_result <= '0;
        end else begin
            Status        <= (state_next == ST_RUN);
            engine_nreset <= (state_next != ST_CLEAR);
            if (accept) begin
                KerT         <= KerT_in;
                Se05sigmaT   <= Se05sigmaT_in;
                sigmaSqrtT   <= sigmaSqrtT_in;
                Mode         <= mode_in;
                n_q          <= n_samples;
                sample_total <= 35'(n_samples) * 35'(LANES);
                progress     <= '0;
            end else if (state == ST_RUN && progress < n_q) begin
                progress <= progress + 32'd1;
            end
            if (state == ST_DRAIN && state_next == ST_DONE) begin
                sum_result        <= sum_in;
                sum_square_result <= sum_square_in;
            end
        end
    end

endmodule

// File: tb/tb_mc_run_controller.sv
// Bench for mc_run_controller: directed scenarios plus randomized runs,
// checked against a cycle-offset model of a run derived from phase lengths.
module tb_mc_run_controller;
    import mc_pkg::*;

    localparam int C = 2;
    localparam int F = 8;
    localparam int D = 4;
    localparam int L = 5;

    logic               clk = 1'b0;
    logic               reset, start, abort, result_ack, mode_in;
    logic [31:0]        n_samples;
    logic signed [15:0] KerT_in, Se05sigmaT_in, sigmaSqrtT_in;
    logic [63:0]        sum_in, sum_square_in;
    logic signed [15:0] KerT, Se05sigmaT, sigmaSqrtT;
    logic               Mode, Status, engine_nreset, busy, done;
    logic [63:0]        sum_result, sum_square_result;
    logic [34:0]        sample_total;
    logic [31:0]        progress;
    mc_state_e          state;

    int vectors = 0;
    int fails   = 0;

    // reference model state
    logic signed [15:0] exp_ker, exp_se, exp_sig;
    logic               exp_mode;
    logic [63:0]        exp_sum, exp_sq;
    logic [34:0]        exp_total;

    always #5 clk = ~clk;

    mc_run_controller dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .result_ack(result_ack), .n_samples(n_samples),
        .KerT_in(KerT_in), .Se05sigmaT_in(Se05sigmaT_in),
        .sigmaSqrtT_in(sigmaSqrtT_in), .mode_in(mode_in),
        .sum_in(sum_in), .sum_square_in(sum_square_in),
        .KerT(KerT), .Se05sigmaT(Se05sigmaT), .sigmaSqrtT(sigmaSqrtT),
        .Mode(Mode), .Status(Status), .engine_nreset(engine_nreset),
        .busy(busy), .done(done), .sum_result(sum_result),
        .sum_square_result(sum_square_result), .sample_total(sample_total),
        .progress(progress), .state(state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_state", 64'(state), 64'(ST_IDLE));
        chk("rst_status", 64'(Status), 64'd0);
        chk("rst_nreset", 64'(engine_nreset), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_progress", 64'(progress), 64'd0);
        chk("rst_total", 64'(sample_total), 64'd0);
        chk("rst_sum", sum_result, 64'd0);
        chk("rst_sumsq", sum_square_result, 64'd0);
        chk("rst_kert", 64'(KerT), 64'd0);
        chk("rst_se", 64'(Se05sigmaT), 64'd0);
        chk("rst_sig", 64'(sigmaSqrtT), 64'd0);
        chk("rst_mode", 64'(Mode), 64'd0);
        exp_ker = '0; exp_se = '0; exp_sig = '0; exp_mode = 1'b0;
        exp_sum = '0; exp_sq = '0; exp_total = '0;
    endtask

    // Put a fresh random job on the inputs and record what should be latched.
    task automatic drive_job(input logic [31:0] n, input logic [63:0] s, input logic [63:0] sq);
        n_samples     = n;
        KerT_in       = 16'($urandom);
        Se05sigmaT_in = 16'($urandom);
        sigmaSqrtT_in = 16'($urandom);
        mode_in       = 1'($urandom);
        sum_in        = s;
        sum_square_in = sq;
        exp_ker   = KerT_in;
        exp_se    = Se05sigmaT_in;
        exp_sig   = sigmaSqrtT_in;
        exp_mode  = mode_in;
        exp_total = 35'(64'(n) * 64'(L));
        start     = 1'b1;
    endtask

    // Scribble over the parameter inputs with start high; must be ignored.
    task automatic poke_start();
        start         = 1'b1;
        n_samples     = $urandom;
        KerT_in       = 16'($urandom);
        Se05sigmaT_in = 16'($urandom);
        sigmaSqrtT_in = 16'($urandom);
        mode_in       = 1'($urandom);
    endtask

    // Expected outputs i edges after the edge that sampled start.
    task automatic chk_cycle(input int i, input int n);
        int lat;
        int prog;
        lat  = 1 + C + F + n + D;
        prog = (i <= C + F + 1) ? 0 : (i - (C + F + 1));
        if (prog > n) prog = n;
        chk($sformatf("status@%0d", i), 64'(Status), 64'((i >= C + F + 1) && (i <= C + F + n)));
        chk($sformatf("nreset@%0d", i), 64'(engine_nreset), 64'(!(i >= 1 && i <= C)));
        chk($sformatf("busy@%0d", i), 64'(busy), 64'd1);
        chk($sformatf("done@%0d", i), 64'(done), 64'(i == lat));
        chk($sformatf("progress@%0d", i), 64'(progress), 64'(prog));
        chk($sformatf("kert@%0d", i), 64'(KerT), 64'(exp_ker));
        chk($sformatf("mode@%0d", i), 64'(Mode), 64'(exp_mode));
        if (i == lat) begin
            exp_sum = sum_in;
            exp_sq  = sum_square_in;
        end
        chk($sformatf("sum@%0d", i), sum_result, exp_sum);
        chk($sformatf("sumsq@%0d", i), sum_square_result, exp_sq);
        if (i == 1) chk("total", 64'(sample_total), 64'(exp_total));
    endtask

    // Full run: start, walk every cycle to done, optional pokes, acknowledge.
    task automatic run_job(input logic [31:0] n, input logic [63:0] s, input logic [63:0] sq,
                           input bit pokes);
        int lat;
        lat = 1 + C + F + int'(n) + D;
        drive_job(n, s, sq);
        step();
        start = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            chk_cycle(i, int'(n));
            result_ack = 1'b0;
            start      = 1'b0;
            if (pokes && i == 2) result_ack = 1'b1;
            if (pokes && i == C + F + 2 && n > 2) poke_start();
            if (i < lat) step();
        end
        if (pokes) begin
            for (int j = 0; j < 2; j++) begin
                poke_start();
                step();
                start = 1'b0;
                chk("done_hold", 64'(done), 64'd1);
                chk("done_kert", 64'(KerT), 64'(exp_ker));
                chk("done_se", 64'(Se05sigmaT), 64'(exp_se));
                chk("done_sig", 64'(sigmaSqrtT), 64'(exp_sig));
                chk("done_total", 64'(sample_total), 64'(exp_total));
            end
        end
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        chk("ack_done", 64'(done), 64'd0);
        chk("ack_busy", 64'(busy), 64'd0);
        chk("ack_sum", sum_result, exp_sum);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; result_ack = 1'b0;
        n_samples = '0; KerT_in = '0; Se05sigmaT_in = '0; sigmaSqrtT_in = '0;
        mode_in = 1'b0; sum_in = '0; sum_square_in = '0;
        step();
        step();
        chk_reset_values();
        reset = 1'b0;
        step();
        chk("post_rst_nreset", 64'(engine_nreset), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);

        // Basic run: 10 samples, constant sum
        run_job(32'd10, 64'h1234, 64'h5678_9abc, 1'b0);
        chk("n10_total", 64'(sample_total), 64'd50);

        // Zero samples: straight from FLUSH to DRAIN
        run_job(32'd0, 64'($urandom), 64'($urandom), 1'b0);
        chk("n0_total", 64'(sample_total), 64'd0);

        // Ignored start in RUN and DONE, ignored ack outside DONE
        run_job(32'd12, {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)}, 1'b1);

        // Abort in the third RUN cycle; results retained, no done
        drive_job(32'd100, 64'hdead_beef, 64'hfeed_f00d);
        step();
        start = 1'b0;
        for (int i = 1; i <= C + F + 3; i++) begin
            chk_cycle(i, 100);
            if (i < C + F + 3) step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_status", 64'(Status), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum", sum_result, exp_sum);
        chk("abort_sumsq", sum_square_result, exp_sq);
        for (int j = 0; j < 20; j++) begin
            step();
            chk("abort_idle_done", 64'(done), 64'd0);
        end

        // Abort together with start in IDLE: start must not be accepted
        drive_job(32'd5, 64'd1, 64'd1);
        abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 64'(busy), 64'd0);

        // Maximum sample count: sample_total keeps all 35 bits
        drive_job(32'hFFFF_FFFF, 64'd0, 64'd0);
        step();
        start = 1'b0;
        chk("max_total", 64'(sample_total), 64'h4_FFFF_FFFB);
        chk("max_total_model", 64'(sample_total), 64'(exp_total));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("max_abort_busy", 64'(busy), 64'd0);

        // Reset in the middle of FLUSH, then a normal run
        drive_job(32'd7, 64'd99, 64'd77);
        step();
        start = 1'b0;
        for (int i = 0; i < C + 2; i++) step();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        step();
        chk_reset_values();
        reset = 1'b0;
        step();
        chk("rerun_nreset", 64'(engine_nreset), 64'd1);
        run_job(32'd7, 64'($urandom), 64'($urandom), 1'b0);

        // Randomized runs
        for (int r = 0; r < 5; r++) begin
            run_job(32'($urandom_range(0, 30)), {32'($urandom), 32'($urandom)},
                    {32'($urandom), 32'($urandom)}, 1'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
